// File: rtl/zh_1hot_lookup_feeder_if.sv
// Config, request and response bundle for zh_1hot_lookup_feeder.
// The _i/_o suffixes give each signal's direction as seen from the feeder.
interface zh_1hot_lookup_feeder_if #(
   parameter int RESULT_WIDTH = 3,
   parameter int NUM_LOOKUPS  = 8,
   parameter int NUM_CHOICES  = 2,
   parameter int SEL_WIDTH    = (NUM_CHOICES > 1) ? $clog2(NUM_CHOICES) : 1,
   parameter int ADDR_WIDTH   = (NUM_LOOKUPS*NUM_CHOICES > 1) ? $clog2(NUM_LOOKUPS*NUM_CHOICES) : 1
);
   logic                              cfg_wr_en_i;
   logic                              cfg_wr_ready_o;
   logic [ADDR_WIDTH-1:0]             cfg_addr_i;
   logic [RESULT_WIDTH-1:0]           cfg_data_i;
   logic                              req_valid_i;
   logic                              req_ready_o;
   logic [NUM_LOOKUPS*SEL_WIDTH-1:0]  req_sel_i;
   logic [NUM_LOOKUPS-1:0]            req_mask_i;
   logic                              rsp_valid_o;
   logic                              rsp_ready_i;
   logic [RESULT_WIDTH*NUM_LOOKUPS-1:0] rsp_data_o;

   modport master (
      output cfg_wr_en_i, cfg_addr_i, cfg_data_i, req_valid_i, req_sel_i, req_mask_i, rsp_ready_i,
      input  cfg_wr_ready_o, req_ready_o, rsp_valid_o, rsp_data_o
   );
   modport slave (
      input  cfg_wr_en_i, cfg_addr_i, cfg_data_i, req_valid_i, req_sel_i, req_mask_i, rsp_ready_i,
      output cfg_wr_ready_o, req_ready_o, rsp_valid_o, rsp_data_o
   );
endinterface

// File: rtl/zh_1hot_lookup_feeder.sv
// Feeder for zh_1hot_lookup_table: programmable table, one-hot select stage, result capture stage.
// Optional out-of-range select check is built when ZH_LKT_FEEDER_SEL_CHECK_EN is defined.
module zh_1hot_lookup_feeder #(
   parameter int RESULT_WIDTH = 3,
   parameter int NUM_LOOKUPS  = 8,
   parameter int NUM_CHOICES  = 2
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   zh_1hot_lookup_feeder_if.slave                        bus,
   output logic [NUM_LOOKUPS*NUM_CHOICES*RESULT_WIDTH-1:0] lookup_table_o,
   output logic [NUM_LOOKUPS*NUM_CHOICES-1:0]            input_o,
   input  logic [RESULT_WIDTH*NUM_LOOKUPS-1:0]           result_i,
   output logic                                          sel_err_o
);
   localparam int NE         = NUM_LOOKUPS*NUM_CHOICES;
   localparam int SEL_WIDTH  = (NUM_CHOICES > 1) ? $clog2(NUM_CHOICES) : 1;
   localparam int ADDR_WIDTH = (NE > 1) ? $clog2(NE) : 1;

   logic [NE-1:0][RESULT_WIDTH-1:0]     table_q, table_d;
   logic                                s1_valid_q, s1_valid_d;
   logic [NE-1:0]                       sel_q, sel_d, onehot;
   logic                                rsp_valid_q, rsp_valid_d;
   logic [RESULT_WIDTH*NUM_LOOKUPS-1:0] rsp_data_q, rsp_data_d;
   logic                                accept, s1_adv, wr_fire;

   assign s1_adv             = s1_valid_q && (!rsp_valid_q || bus.rsp_ready_i);
   assign bus.req_ready_o    = !s1_valid_q || s1_adv;
   // Table is frozen while S1 holds selects whose result has not been captured yet.
   assign bus.cfg_wr_ready_o = !s1_valid_q;
   assign accept             = bus.req_valid_i && bus.req_ready_o;
   assign wr_fire            = bus.cfg_wr_en_i && !s1_valid_q &&
                               ({1'b0, bus.cfg_addr_i} < (ADDR_WIDTH+1)'(NE));

   assign lookup_table_o = table_q;
   assign input_o        = sel_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = rsp_data_q;

`ifdef ZH_LKT_FEEDER_SEL_CHECK_EN
   logic [NUM_LOOKUPS-1:0] oor;
`endif

   for (genvar f = 0; f < NUM_LOOKUPS; f++) begin : g_lkp
      logic [SEL_WIDTH-1:0] idx;
      assign idx = bus.req_sel_i[f*SEL_WIDTH +: SEL_WIDTH];
      for (genvar g = 0; g < NUM_CHOICES; g++) begin : g_ch
         assign onehot[f*NUM_CHOICES+g] = bus.req_mask_i[f] && (idx == SEL_WIDTH'(g));
      end
`ifdef ZH_LKT_FEEDER_SEL_CHECK_EN
      assign oor[f] = bus.req_mask_i[f] && ({1'b0, idx} >= (SEL_WIDTH+1)'(NUM_CHOICES));
`endif
   end

   always_comb begin
      table_d = table_q;
      for (int e = 0; e < NE; e++)
         if (wr_fire && (bus.cfg_addr_i == ADDR_WIDTH'(e))) table_d[e] = bus.cfg_data_i;
      s1_valid_d = s1_valid_q;
      sel_d      = sel_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         sel_d      = onehot;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
         sel_d      = '0;
      end
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (s1_adv) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = result_i;
      end else if (bus.rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         table_q     <= '0;
         s1_valid_q  <= 1'b0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         table_q     <= table_d;
         s1_valid_q  <= s1_valid_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef ZH_LKT_FEEDER_SEL_CHECK_EN
   logic sel_err_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)              sel_err_q <= 1'b0;
      else if (accept && |oor) sel_err_q <= 1'b1;
   end
   assign sel_err_o = sel_err_q;
`else
   assign sel_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_zh_1hot_lookup_feeder.sv
// Scoreboard bench for zh_1hot_lookup_feeder; a second instance with three choices covers out-of-range selects.
module tb_zh_1hot_lookup_feeder;
   localparam int RW = 3, NL = 8, NC = 2, NE = NL*NC, SW = 1;
   localparam int NC3 = 3, NE3 = NL*NC3, SW3 = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   zh_1hot_lookup_feeder_if #(.RESULT_WIDTH(RW), .NUM_LOOKUPS(NL), .NUM_CHOICES(NC))  bus ();
   zh_1hot_lookup_feeder_if #(.RESULT_WIDTH(RW), .NUM_LOOKUPS(NL), .NUM_CHOICES(NC3)) bus3 ();

   logic [NE*RW-1:0]  lut;
   logic [NE-1:0]     onehot;
   logic [RW*NL-1:0]  res;
   logic              err;
   logic [NE3*RW-1:0] lut3;
   logic [NE3-1:0]    onehot3;
   logic [RW*NL-1:0]  res3;
   logic              err3;

   zh_1hot_lookup_feeder #(.RESULT_WIDTH(RW), .NUM_LOOKUPS(NL), .NUM_CHOICES(NC)) u_dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .lookup_table_o(lut), .input_o(onehot),
      .result_i(res), .sel_err_o(err));
   zh_1hot_lookup_feeder #(.RESULT_WIDTH(RW), .NUM_LOOKUPS(NL), .NUM_CHOICES(NC3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .bus(bus3), .lookup_table_o(lut3), .input_o(onehot3),
      .result_i(res3), .sel_err_o(err3));

   // Downstream combinational lookup table: OR of selected entries per lookup.
   always_comb begin
      res = '0;
      for (int f = 0; f < NL; f++)
         for (int g = 0; g < NC; g++)
            if (onehot[f*NC+g]) res[f*RW +: RW] = res[f*RW +: RW] | lut[(f*NC+g)*RW +: RW];
   end
   always_comb begin
      res3 = '0;
      for (int f = 0; f < NL; f++)
         for (int g = 0; g < NC3; g++)
            if (onehot3[f*NC3+g]) res3[f*RW +: RW] = res3[f*RW +: RW] | lut3[(f*NC3+g)*RW +: RW];
   end

   int n_vec = 0;
   int n_err = 0;
   logic [RW-1:0]    sh [NE];
   logic [RW-1:0]    sh3 [NE3];
   logic [RW*NL-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [RW*NL-1:0] exp_of(input logic [NL*SW-1:0] s, input logic [NL-1:0] m);
      logic [RW*NL-1:0] r;
      r = '0;
      for (int f = 0; f < NL; f++) begin
         int idx;
         idx = int'(s[f*SW +: SW]);
         if (m[f] && idx < NC) r[f*RW +: RW] = sh[f*NC+idx];
      end
      return r;
   endfunction

   function automatic logic [NE*RW-1:0] sh_flat();
      logic [NE*RW-1:0] r;
      for (int e = 0; e < NE; e++) r[e*RW +: RW] = sh[e];
      return r;
   endfunction

   // Monitor: shadow table writes, expected-result pushes and response pops.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.cfg_wr_en_i && bus.cfg_wr_ready_o && int'(bus.cfg_addr_i) < NE)
            sh[int'(bus.cfg_addr_i)] = bus.cfg_data_i;
         if (bus.req_valid_i && bus.req_ready_o)
            exp_q.push_back(exp_of(bus.req_sel_i, bus.req_mask_i));
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (exp_q.size() == 0) chk("rsp_extra", 64'(bus.rsp_data_o), 64'hDEAD);
            else                   chk("rsp", 64'(bus.rsp_data_o), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_req(input logic [NL*SW-1:0] s, input logic [NL-1:0] m);
      bus.req_valid_i = 1'b1;
      bus.req_sel_i   = s;
      bus.req_mask_i  = m;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.req_ready_o) break;
      end
      chk("req_rdy", 64'(bus.req_ready_o), 64'd1);
      @(posedge clk); #1 bus.req_valid_i = 1'b0;
   endtask

   task automatic cfg_wr(input int a, input logic [RW-1:0] d);
      bus.cfg_wr_en_i = 1'b1;
      bus.cfg_addr_i  = 4'(a);
      bus.cfg_data_i  = d;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.cfg_wr_ready_o) break;
      end
      chk("wr_rdy", 64'(bus.cfg_wr_ready_o), 64'd1);
      @(posedge clk); #1 bus.cfg_wr_en_i = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
      #1 chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [RW*NL-1:0] d0, e3;
      logic [NE-1:0]    i0;
      logic [NL*SW3-1:0] s3;
      time t0;
      int  k;
      bus.cfg_wr_en_i = 0; bus.cfg_addr_i = '0; bus.cfg_data_i = '0;
      bus.req_valid_i = 0; bus.req_sel_i = '0; bus.req_mask_i = '0; bus.rsp_ready_i = 1;
      bus3.cfg_wr_en_i = 0; bus3.cfg_addr_i = '0; bus3.cfg_data_i = '0;
      bus3.req_valid_i = 0; bus3.req_sel_i = '0; bus3.req_mask_i = '0; bus3.rsp_ready_i = 1;
      for (int e = 0; e < NE; e++) sh[e] = '0;

      // Reset values, checked before any clock edge
      #1 rst = 1'b1;
      #2;
      chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data_o), 64'd0);
      chk("rst_table", 64'(lut), 64'd0);
      chk("rst_input", 64'(onehot), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
      chk("rst_cfg_ready", 64'(bus.cfg_wr_ready_o), 64'd1);
      chk("rst_sel_err", 64'(err), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Program entry e = e&7 and read all odd entries
      for (int e = 0; e < NE; e++) cfg_wr(e, 3'(e & 7));
      chk("table", 64'(lut), 64'(sh_flat()));
      send_req('1, 8'hFF);
      chk("onehot_ff", 64'(onehot), 64'hAAAA);
      chk("lat_s2_empty", 64'(bus.rsp_valid_o), 64'd0);
      @(posedge clk); #1;
      chk("lat_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("rsp_ff", 64'(bus.rsp_data_o), 64'({3'd7, 3'd5, 3'd3, 3'd1, 3'd7, 3'd5, 3'd3, 3'd1}));

      // All lookups masked off
      send_req('1, 8'h00);
      chk("onehot_masked", 64'(onehot), 64'd0);
      @(posedge clk); #1 chk("rsp_masked", 64'(bus.rsp_data_o), 64'd0);
      drain();

      // Random back-to-back traffic at full rate
      t0 = $time;
      for (int i = 0; i < 12; i++) send_req(8'($urandom), 8'($urandom));
      chk("throughput", 64'(($time - t0) / 10), 64'd12);
      drain();

      // Backpressure: two accepted, third held off
      bus.rsp_ready_i = 1'b0;
      send_req(8'h0F, 8'hFF);
      send_req(8'hF0, 8'hFF);
      chk("full_cnt", 64'(exp_q.size()), 64'd2);
      bus.req_valid_i = 1'b1; bus.req_sel_i = 8'h55; bus.req_mask_i = 8'hFF;
      @(negedge clk);
      chk("full_req_ready", 64'(bus.req_ready_o), 64'd0);
      d0 = bus.rsp_data_o;
      i0 = onehot;
      repeat (3) @(negedge clk);
      chk("full_rsp_stable", 64'(bus.rsp_data_o), 64'(d0));
      chk("full_input_stable", 64'(onehot), 64'(i0));
      chk("full_req_ready2", 64'(bus.req_ready_o), 64'd0);
      @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1 bus.req_valid_i = 1'b0;
      drain();

      // Config write blocked while S1 is occupied
      bus.rsp_ready_i = 1'b0;
      send_req(8'h33, 8'hFF);
      send_req(8'hCC, 8'hFF);
      bus.cfg_wr_en_i = 1'b1; bus.cfg_addr_i = 4'd5; bus.cfg_data_i = 3'd2;
      repeat (2) begin
         @(negedge clk);
         chk("cfg_blocked", 64'(bus.cfg_wr_ready_o), 64'd0);
         chk("table_held", 64'(lut[5*RW +: RW]), 64'd5);
      end
      @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
      k = 0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.cfg_wr_ready_o) break;
      end
      chk("cfg_first_free", 64'(k), 64'd1);
      @(posedge clk); #1 bus.cfg_wr_en_i = 1'b0;
      chk("cfg_landed", 64'(lut[5*RW +: RW]), 64'd2);
      drain();

      // Same-cycle write and request: the request sees the new value
      bus.cfg_wr_en_i = 1'b1; bus.cfg_addr_i = 4'd1; bus.cfg_data_i = 3'd6;
      bus.req_valid_i = 1'b1; bus.req_sel_i = 8'hFF; bus.req_mask_i = 8'h01;
      @(negedge clk);
      chk("both_ready", 64'({bus.req_ready_o, bus.cfg_wr_ready_o}), 64'd3);
      @(posedge clk); #1 bus.cfg_wr_en_i = 1'b0; bus.req_valid_i = 1'b0;
      @(posedge clk); #1 chk("wr_and_req", 64'(bus.rsp_data_o), 64'd6);
      drain();

      // Reset with both stages full takes effect without a clock edge
      bus.rsp_ready_i = 1'b0;
      send_req(8'hFF, 8'hFF);
      send_req(8'h00, 8'hFF);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("mid_rst_table", 64'(lut), 64'd0);
      chk("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
      chk("mid_rst_input", 64'(onehot), 64'd0);
      chk("mid_rst_rsp_data", 64'(bus.rsp_data_o), 64'd0);
      exp_q.delete();
      for (int e = 0; e < NE; e++) sh[e] = '0;
      @(posedge clk); #1 rst = 1'b0; bus.rsp_ready_i = 1'b1;

      // Three-choice instance: index 3 on lookup 0 is out of range
      bus3.cfg_wr_en_i = 1'b1;
      for (int e = 0; e < NE3; e++) begin
         sh3[e] = 3'((e % 7) + 1);
         bus3.cfg_addr_i = 5'(e);
         bus3.cfg_data_i = sh3[e];
         @(posedge clk); #1;
      end
      bus3.cfg_wr_en_i = 1'b0;
      s3 = '0;
      e3 = '0;
      s3[1:0] = 2'd3;
      for (int f = 1; f < NL; f++) begin
         s3[f*SW3 +: SW3] = 2'(f % 3);
         e3[f*RW +: RW]   = sh3[f*NC3 + f % 3];
      end
      chk("nc3_req_ready", 64'(bus3.req_ready_o), 64'd1);
      bus3.req_valid_i = 1'b1; bus3.req_sel_i = s3; bus3.req_mask_i = 8'hFF;
      @(posedge clk); #1 bus3.req_valid_i = 1'b0;
      chk("nc3_onehot_l0", 64'(onehot3[2:0]), 64'd0);
      @(posedge clk); #1;
      chk("nc3_rsp", 64'(bus3.rsp_data_o), 64'(e3));
`ifdef ZH_LKT_FEEDER_SEL_CHECK_EN
      chk("nc3_sel_err", 64'(err3), 64'd1);
`else
      chk("nc3_sel_err", 64'(err3), 64'd0);
`endif
      e3 = '0;
      for (int f = 0; f < NL; f++) e3[f*RW +: RW] = sh3[f*NC3];
      bus3.req_valid_i = 1'b1; bus3.req_sel_i = '0; bus3.req_mask_i = 8'hFF;
      @(posedge clk); #1 bus3.req_valid_i = 1'b0;
      @(posedge clk); #1;
      chk("nc3_rsp_clean", 64'(bus3.rsp_data_o), 64'(e3));
`ifdef ZH_LKT_FEEDER_SEL_CHECK_EN
      chk("nc3_sel_err_sticky", 64'(err3), 64'd1);
`else
      chk("nc3_sel_err_sticky", 64'(err3), 64'd0);
`endif
      chk("nc2_sel_err", 64'(err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
